instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Upstream control stage of the 8-bit CPU.
- Drives the 16x8 memory's read port (address, rw) from a program counter and captures the registered read data.
- Splits each byte into opcode/operand and hands it to the decode/execute stage over a valid/ready handshake.
- Supports jumps (flush and redirect) and a halt opcode that parks fetching.

Parameters:
ADDR_W  4      memory address / PC width (memory depth 2**ADDR_W)
DATA_W  8      instruction width
OPC_W   4      opcode width; operand width = DATA_W-OPC_W
HALT_OP 4'hF   opcode that stops fetching after delivery
RESET_PC 0     PC value after reset

Ports:
clk          in   1        clock, all logic on rising edge
clr          in   1        reset; one clock, reset asynchronous, active-low (clr=0 resets)
mem_addr     out  ADDR_W   address to memory
mem_rw       out  1        memory rw; tied 0 (read) in all states
mem_data     in   DATA_W   memory data_out; valid on the edge after the read address was registered
instr_valid  out  1        opcode/operand/instr_pc hold a valid instruction
instr_ready  in   1        consumer accepts on valid&ready at a rising edge
opcode       out  OPC_W    mem_data[DATA_W-1 -: OPC_W]
operand      out  DATA_W-OPC_W  mem_data low bits
instr_pc     out  ADDR_W   address the delivered instruction came from
jump_en      in   1        redirect request, one-cycle pulse
jump_addr    in   ADDR_W   redirect target
pc           out  ADDR_W   next address to fetch
halted       out  1        fetch parked after HALT_OP delivered
fetch_count  out  8        instructions delivered, saturates at 255

Behaviour:
- Reset (clr low, async): state=FETCH, pc=mem_addr=RESET_PC, mem_rw=0, instr_valid=0, opcode=0, operand=0, instr_pc=0, halted=0, fetch_count=0.
- States:
  - FETCH: mem_addr=pc. Next state is WAIT.
  - WAIT: memory registers data at the entry edge. At the exit edge, capture mem_data into opcode/operand, set instr_pc=pc, pc<=pc+1 (wraps 2**ADDR_W-1 -> 0), instr_valid<=1. Next state is HOLD.
  - HOLD: outputs stable while instr_valid=1 and !instr_ready. On valid&ready: instr_valid<=0, fetch_count+1 (saturating). Then:
    - if opcode==HALT_OP: go HALTED, halted<=1;
    - else go FETCH.
  - HALTED: no fetch, instr_valid=0, mem_addr holds pc. Leaves only on jump_en.
- Latency: address out to instruction valid is 2 cycles. Best-case throughput is 1 instruction / 3 cycles (ready held high).
- mem_addr is registered, always equal to pc. mem_rw never asserts; the block never writes memory.
- jump_en (any state, highest priority, sampled at the edge):
  - pc<=jump_addr, mem_addr<=jump_addr, state<=FETCH, instr_valid<=0, halted<=0.
  - Any in-flight or held instruction is discarded.
  - If valid&ready coincide with jump_en, the held instruction counts as accepted (fetch_count increments), then the jump applies.
  - A HALT_OP accepted in the same cycle as jump_en does not halt.
- Jump during WAIT: the returning data is dropped; the new fetch starts the next cycle.
- Reset mid-operation clears the held instruction immediately (instr_valid drops asynchronously).
- instr_ready while instr_valid=0 is ignored.

Test Plan:
- Mem[0..2]=8'h12,8'h34,8'hF0, release clr, ready=1 -> mem_addr 0,1,2. Delivered (opcode,operand,instr_pc) = (1,2,0),(3,4,1),(F,0,2), 3 cycles apart. Then halted=1, fetch_count=3, mem_addr stays 3.
- Hold ready=0 for 5 cycles with valid instruction -> outputs unchanged and pc not advanced. Raise ready -> one acceptance, fetch_count+1.
- Start pc=15, mem[15]=8'h21, mem[0]=8'h55 -> instr_pc=15 then pc wraps to 0; next delivered opcode 5, operand 5.
- jump_en to 4'h9 while in WAIT (mem[9]=8'h7A) -> stale data never valid. Next valid is opcode 7, operand A, instr_pc 9.
- In HALTED, pulse jump_en with jump_addr=2 -> halted=0 next cycle, fetch resumes at 2. With ready=1 and jump_en in the same HOLD cycle, fetch_count increments and pc=jump_addr.
- Assert clr low mid-HOLD, asynchronous to clk -> instr_valid=0, pc=0, fetch_count=0 immediately. After release, fetching restarts at address 0.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: memory read port plus the instruction handoff to decode.
// Combinational wiring only, no latency of its own.
// Backpressure is carried by instr_ready from the consumer side.
interface instr_fetch_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int OPC_W  = 4
);
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_rw;
    logic [DATA_W-1:0]       mem_data;
    logic                    instr_valid;
    logic                    instr_ready;
    logic [OPC_W-1:0]        opcode;
    logic [DATA_W-OPC_W-1:0] operand;
    logic [ADDR_W-1:0]       instr_pc;

    // Fetch unit side: drives the memory address and presents instructions.
    modport master (
        output mem_addr, mem_rw, instr_valid, opcode, operand, instr_pc,
        input  mem_data, instr_ready
    );

    // Memory plus decode side: returns read data and accepts instructions.
    modport slave (
        input  mem_addr, mem_rw, instr_valid, opcode, operand, instr_pc,
        output mem_data, instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: walks a PC over a synchronous-read memory and hands bytes to decode.
// Latency: address out to instr_valid is 2 cycles; best case one instruction every 3 cycles.
// Backpressure: the instruction is held stable in HOLD until instr_ready; the PC does not advance meanwhile.
module instr_fetch #(
    parameter int              ADDR_W   = 4,
    parameter int              DATA_W   = 8,
    parameter int              OPC_W    = 4,
    parameter logic [OPC_W-1:0] HALT_OP = 4'hF,
    parameter int              RESET_PC = 0
) (
    input  logic              clk,
    input  logic              clr,
    instr_fetch_if.master     bus,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [7:0]        fetch_count
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_W-1:0]       pc_q;
    logic [OPC_W-1:0]        opc_q;
    logic [DATA_W-OPC_W-1:0] opr_q;
    logic [ADDR_W-1:0]       ipc_q;
    logic [7:0]              cnt_q;
    logic                    accept;

    // A held instruction is taken only while it is actually on offer.
    assign accept = (state == S_HOLD) && bus.instr_ready;

    // State register; reset drops any held instruction immediately.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a jump overrides everything and restarts fetching.
    always_comb begin
        state_nxt = state;
        if (jump_en) begin
            state_nxt = S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state_nxt = S_WAIT;
                S_WAIT:   state_nxt = S_HOLD;
                S_HOLD: begin
                    if (bus.instr_ready) begin
                        state_nxt = (opc_q == HALT_OP) ? S_HALTED : S_FETCH;
                    end
                end
                S_HALTED: state_nxt = S_HALTED;
                default:  state_nxt = S_FETCH;
            endcase
        end
    end

    // PC and instruction capture; a jump in WAIT discards the returning byte.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc_q  <= PC_INIT;
            opc_q <= '0;
            opr_q <= '0;
            ipc_q <= '0;
        end else if (jump_en) begin
            pc_q <= jump_addr;
        end else if (state == S_WAIT) begin
            opc_q <= bus.mem_data[DATA_W-1 -: OPC_W];
            opr_q <= bus.mem_data[DATA_W-OPC_W-1:0];
            ipc_q <= pc_q;
            pc_q  <= pc_q + 1'b1;
        end
    end

    // Delivered-instruction counter, saturating; acceptance counts even alongside a jump.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
        end else if (accept && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // Outputs decoded from state and registers; the memory is only ever read.
    always_comb begin
        bus.mem_addr    = pc_q;
        bus.mem_rw      = 1'b0;
        bus.instr_valid = (state == S_HOLD);
        bus.opcode      = opc_q;
        bus.operand     = opr_q;
        bus.instr_pc    = ipc_q;
        pc              = pc_q;
        halted          = (state == S_HALTED);
        fetch_count     = cnt_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: program-stream reference model with a scoreboard monitor.
// Memory is modelled as a synchronous-read array behind the interface.
// Random ready and jump stimulus plus directed scenarios.
module tb_instr_fetch;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int OW = 4;

    typedef struct packed {
        logic [3:0] opc;
        logic [3:0] opr;
        logic [3:0] pc;
    } item_t;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       jump_en = 1'b0;
    logic [3:0] jump_addr = 4'd0;
    logic [3:0] pc;
    logic       halted;
    logic [7:0] fetch_count;

    instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW), .OPC_W(OW)) bus ();

    instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .OPC_W(OW), .HALT_OP(4'hF), .RESET_PC(0)) dut (
        .clk         (clk),
        .clr         (clr),
        .bus         (bus),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .pc          (pc),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_pass  = 0;
    int    n_total = 0;
    item_t exp_q[$];
    int    acc_cyc[$];
    int    exp_count = 0;
    logic  exp_halted = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Expected delivery order from a start address: sequential, wrapping, ending at a halt.
    task automatic push_stream(input logic [3:0] start);
        logic [3:0] p;
        item_t      it;
        p = start;
        exp_q.delete();
        for (int i = 0; i < 300; i++) begin
            it.opc = mem[p][7:4];
            it.opr = mem[p][3:0];
            it.pc  = p;
            exp_q.push_back(it);
            if (mem[p][7:4] == 4'hF) break;
            p = p + 4'd1;
        end
    endtask

    task automatic fill_mem(input bit no_halt);
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            if (no_halt && b[7:4] == 4'hF) b[7:4] = 4'hE;
            mem[i] = b;
        end
    endtask

    // Monitor: runs between edges, checks what the DUT presents against the model.
    task automatic mon_sample();
        item_t      f;
        logic [3:0] nx;
        if (!clr) begin
            exp_count  = 0;
            exp_halted = 1'b0;
            chk("valid_in_reset", bus.instr_valid, 0);
            return;
        end
        chk("fetch_count", fetch_count, exp_count);
        chk("halted", halted, exp_halted);
        chk("mem_addr_eq_pc", bus.mem_addr, pc);
        chk("mem_rw", bus.mem_rw, 0);
        if (exp_halted) chk("valid_when_halted", bus.instr_valid, 0);
        if (bus.instr_valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_valid: got opcode %0h instr_pc %0h, none expected at t=%0t",
                         bus.opcode, bus.instr_pc, $time);
            end else begin
                f  = exp_q[0];
                nx = f.pc + 4'd1;
                chk("opcode", bus.opcode, f.opc);
                chk("operand", bus.operand, f.opr);
                chk("instr_pc", bus.instr_pc, f.pc);
                chk("pc_while_valid", pc, nx);
                if (bus.instr_ready) begin
                    void'(exp_q.pop_front());
                    acc_cyc.push_back(cyc);
                    if (exp_count != 255) exp_count++;
                    if (!jump_en && f.opc == 4'hF) exp_halted = 1'b1;
                end
            end
        end
        if (jump_en) exp_halted = 1'b0;
    endtask

    task automatic step(input logic rdy, input logic jmp, input logic [3:0] ja);
        bus.instr_ready = rdy;
        jump_en         = jmp;
        jump_addr       = ja;
        @(posedge clk);
        #1;
        if (jmp) push_stream(ja);
        jump_en = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input logic rdy);
        int n;
        n = 0;
        while (!bus.instr_valid && n < budget) begin
            step(rdy, 1'b0, 4'd0);
            n++;
        end
        chk("wait_valid", bus.instr_valid, 1);
    endtask

    task automatic assert_reset();
        #3;
        clr = 1'b0;
        #1;
        exp_q.delete();
        acc_cyc.delete();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;
        push_stream(4'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        fork
            forever begin
                @(negedge clk);
                mon_sample();
            end
        join_none

        // Reset state
        #1;
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_opcode", bus.opcode, 0);
        chk("rst_operand", bus.operand, 0);
        chk("rst_instr_pc", bus.instr_pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_count", fetch_count, 0);

        // Straight-line program ending in a halt, ready held high
        fill_mem(1'b1);
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'hF0;
        @(posedge clk); #1;
        release_reset();
        repeat (14) step(1'b1, 1'b0, 4'd0);
        chk("t1_accepts", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            chk("t1_gap01", acc_cyc[1] - acc_cyc[0], 3);
            chk("t1_gap12", acc_cyc[2] - acc_cyc[1], 3);
        end
        chk("t1_halted", halted, 1);
        chk("t1_count", fetch_count, 3);
        chk("t1_mem_addr", bus.mem_addr, 3);
        repeat (4) step(1'b1, 1'b0, 4'd0);
        chk("t1_mem_addr_parked", bus.mem_addr, 3);

        // Backpressure: hold ready low for five cycles
        assert_reset();
        fill_mem(1'b1);
        mem[0] = 8'h5C; mem[1] = 8'h3B;
        release_reset();
        wait_valid(10, 1'b0);
        repeat (5) step(1'b0, 1'b0, 4'd0);
        chk("t2_valid_held", bus.instr_valid, 1);
        chk("t2_opcode", bus.opcode, 5);
        chk("t2_operand", bus.operand, 4'hC);
        chk("t2_pc", pc, 1);
        chk("t2_count_before", fetch_count, 0);
        step(1'b1, 1'b0, 4'd0);
        chk("t2_count_after", fetch_count, 1);
        chk("t2_valid_after", bus.instr_valid, 0);

        // PC wrap from 15 to 0
        assert_reset();
        fill_mem(1'b1);
        mem[15] = 8'h21; mem[0] = 8'h55; mem[1] = 8'hF3;
        release_reset();
        step(1'b0, 1'b1, 4'd15);
        wait_valid(10, 1'b0);
        chk("t3_instr_pc", bus.instr_pc, 15);
        chk("t3_pc_wrapped", pc, 0);
        step(1'b1, 1'b0, 4'd0);
        wait_valid(10, 1'b1);
        chk("t3_opcode", bus.opcode, 5);
        chk("t3_operand", bus.operand, 5);
        chk("t3_instr_pc0", bus.instr_pc, 0);
        step(1'b1, 1'b0, 4'd0);
        wait_valid(10, 1'b1);
        step(1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b0, 4'd0);
        chk("t3_halted", halted, 1);

        // Jump while the read is in flight
        assert_reset();
        fill_mem(1'b1);
        mem[0] = 8'h11; mem[9] = 8'h7A; mem[10] = 8'hF0;
        mem[2] = 8'h4D; mem[12] = 8'h1E;
        release_reset();
        step(1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'd9);
        chk("t4_valid_after_jump", bus.instr_valid, 0);
        wait_valid(10, 1'b0);
        chk("t4_instr_pc", bus.instr_pc, 9);
        chk("t4_opcode", bus.opcode, 7);
        chk("t4_operand", bus.operand, 4'hA);
        step(1'b1, 1'b0, 4'd0);
        wait_valid(10, 1'b1);
        step(1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0);
        chk("t4_halted", halted, 1);
        chk("t4_count", fetch_count, 2);
        chk("t4_mem_addr", bus.mem_addr, 11);

        // Leave halt by jump, then accept and jump on the same edge
        step(1'b0, 1'b1, 4'd2);
        chk("t5_unhalted", halted, 0);
        wait_valid(10, 1'b0);
        chk("t5_instr_pc", bus.instr_pc, 2);
        step(1'b1, 1'b1, 4'd12);
        chk("t5_count", fetch_count, 3);
        chk("t5_pc", pc, 12);
        chk("t5_valid", bus.instr_valid, 0);

        // Asynchronous reset while an instruction is held
        wait_valid(10, 1'b0);
        assert_reset();
        chk("t6_valid", bus.instr_valid, 0);
        chk("t6_pc", pc, 0);
        chk("t6_count", fetch_count, 0);
        chk("t6_halted", halted, 0);
        fill_mem(1'b1);
        mem[0] = 8'h6A;
        release_reset();
        wait_valid(10, 1'b0);
        chk("t6_restart_pc", bus.instr_pc, 0);
        chk("t6_restart_opc", bus.opcode, 6);
        step(1'b1, 1'b0, 4'd0);

        // Random ready and jumps over random programs
        for (int r = 0; r < 8; r++) begin
            assert_reset();
            fill_mem(1'b0);
            release_reset();
            for (int k = 0; k < 300; k++) begin
                logic rdy;
                logic jmp;
                rdy = ($urandom_range(3) != 0);
                jmp = halted ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
                step(rdy, jmp, 4'($urandom));
            end
        end

        // Long halt-free run to reach counter saturation
        assert_reset();
        fill_mem(1'b1);
        release_reset();
        repeat (850) step(1'b1, 1'b0, 4'd0);
        chk("sat_count", fetch_count, 255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
